// File: rtl/lcdseq_arb.sv
// lcdseq_arb: round-robin two-port arbiter and init/strobe/done command sequencer for the serial LCD driver.
// Define LCDSEQ_TIMEOUT_EN to bound the WAIT state to TMOUT cycles and report expiry on tmout.
module lcdseq_arb #(
  parameter int TMOUT = 4096
) (
  input  logic       lcdclk,
  input  logic       lcdrstn,
  input  logic       reqa,
  input  logic       reqb,
  input  logic [2:0] opa,
  input  logic [2:0] opb,
  input  logic [7:0] arga,
  input  logic [7:0] argb,
  output logic       acka,
  output logic       ackb,
  output logic       initlcd,
  output logic       resetlcd,
  output logic       clearlcd,
  output logic       datalcd,
  output logic       addrlcd,
  output logic       eraselcd,
  output logic [7:0] lcddatin,
  input  logic       lcdreset,
  input  logic       lcdclear,
  input  logic       lcddata,
  input  logic       lcdaddr,
  input  logic       lcderase,
  output logic       ready,
  output logic       busy,
  output logic       tmout
);

  typedef enum logic [2:0] {PWRUP, INIT, ISSUE, WAIT, RELEASE, IDLE} state_t;

  localparam logic [1:0] OWN_NONE = 2'd0;
  localparam logic [1:0] OWN_A    = 2'd1;
  localparam logic [1:0] OWN_B    = 2'd2;

  state_t     state;
  logic [2:0] op;
  logic [7:0] arg;
  logic [1:0] owner;
  logic       lastb;
  logic [4:0] oplines;
  logic [4:0] opdec;
  logic       done;
  logic       granta;
  logic       grantb;
  logic [2:0] gop;
  logic [7:0] garg;
  logic       expired;

  assign {eraselcd, addrlcd, datalcd, clearlcd, resetlcd} = oplines;

  // Round-robin: on contention the requester not granted last wins.
  always_comb begin
    granta = reqa && (!reqb || lastb);
    grantb = reqb && (!reqa || !lastb);
    gop    = granta ? opa : opb;
    garg   = granta ? arga : argb;
    opdec  = 5'b00000;
    case (op)
      3'd0:    opdec = 5'b00001;
      3'd1:    opdec = 5'b00010;
      3'd2:    opdec = 5'b00100;
      3'd3:    opdec = 5'b01000;
      3'd4:    opdec = 5'b10000;
      default: opdec = 5'b00000;
    endcase
    done = |(opdec & {lcderase, lcdaddr, lcddata, lcdclear, lcdreset});
  end

`ifdef LCDSEQ_TIMEOUT_EN
  localparam int CW = $clog2(TMOUT + 1);

  logic [CW-1:0] cnt;

  assign expired = (cnt == CW'(TMOUT - 1));

  always_ff @(posedge lcdclk or negedge lcdrstn) begin
    if (!lcdrstn) begin
      cnt <= '0;
    end else if (state == ISSUE) begin
      cnt <= '0;
    end else if (state == WAIT) begin
      cnt <= cnt + CW'(1);
    end
  end
`else
  // Without the counter WAIT never expires.
  assign expired = 1'b0 && (TMOUT > 0);
`endif

  always_ff @(posedge lcdclk or negedge lcdrstn) begin
    if (!lcdrstn) begin
      state    <= PWRUP;
      op       <= 3'd0;
      arg      <= 8'h00;
      owner    <= OWN_NONE;
      lastb    <= 1'b0;
      oplines  <= 5'b00000;
      lcddatin <= 8'h00;
      initlcd  <= 1'b0;
      acka     <= 1'b0;
      ackb     <= 1'b0;
      ready    <= 1'b0;
      busy     <= 1'b0;
      tmout    <= 1'b0;
    end else begin
      initlcd <= 1'b0;
      acka    <= 1'b0;
      ackb    <= 1'b0;
      tmout   <= 1'b0;
      case (state)
        PWRUP: begin
          op      <= 3'd0;
          arg     <= 8'h00;
          owner   <= OWN_NONE;
          initlcd <= 1'b1;
          busy    <= 1'b1;
          state   <= INIT;
        end
        IDLE: begin
          if (granta || grantb) begin
            op    <= gop;
            arg   <= garg;
            owner <= granta ? OWN_A : OWN_B;
            lastb <= grantb;
            busy  <= 1'b1;
            // Illegal opcodes never touch the driver, only the ack.
            if (gop > 3'd4) begin
              acka  <= granta;
              ackb  <= grantb;
              state <= RELEASE;
            end else begin
              initlcd <= 1'b1;
              state   <= INIT;
            end
          end
        end
        INIT: begin
          oplines  <= opdec;
          lcddatin <= arg;
          state    <= ISSUE;
        end
        ISSUE: begin
          state <= WAIT;
        end
        WAIT: begin
          if (done || expired) begin
            oplines <= 5'b00000;
            acka    <= (owner == OWN_A);
            ackb    <= (owner == OWN_B);
            tmout   <= !done && expired;
            if (owner == OWN_NONE) ready <= 1'b1;
            state   <= RELEASE;
          end
        end
        RELEASE: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          state <= PWRUP;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_lcdseq_arb.sv
// tb_lcdseq_arb: randomized requesters and a behavioural LCD driver around lcdseq_arb,
// with an expected-transaction queue checked by an independent output monitor.
module tb_lcdseq_arb;

  localparam int TMO = 16;

  logic       lcdclk = 1'b0;
  logic       lcdrstn = 1'b0;
  logic       reqa = 1'b0;
  logic       reqb = 1'b0;
  logic [2:0] opa = 3'd0;
  logic [2:0] opb = 3'd0;
  logic [7:0] arga = 8'h00;
  logic [7:0] argb = 8'h00;
  logic       acka, ackb, initlcd;
  logic       resetlcd, clearlcd, datalcd, addrlcd, eraselcd;
  logic [7:0] lcddatin;
  logic       ready, busy, tmout;
  logic [4:0] doneflags = 5'b00000;
  wire  [4:0] ops = {eraselcd, addrlcd, datalcd, clearlcd, resetlcd};

  typedef struct {
    int who;
    int op;
    int arg;
    int tmo;
  } exp_t;

  exp_t expq[$];
  int   nchecks = 0;
  int   nfails = 0;
  bit   lastbm = 1'b0;
  bit   stall = 1'b0;

  always #5 lcdclk = ~lcdclk;

  lcdseq_arb #(.TMOUT(TMO)) dut (
    .lcdclk(lcdclk), .lcdrstn(lcdrstn),
    .reqa(reqa), .reqb(reqb), .opa(opa), .opb(opb), .arga(arga), .argb(argb),
    .acka(acka), .ackb(ackb), .initlcd(initlcd),
    .resetlcd(resetlcd), .clearlcd(clearlcd), .datalcd(datalcd),
    .addrlcd(addrlcd), .eraselcd(eraselcd), .lcddatin(lcddatin),
    .lcdreset(doneflags[0]), .lcdclear(doneflags[1]), .lcddata(doneflags[2]),
    .lcdaddr(doneflags[3]), .lcderase(doneflags[4]),
    .ready(ready), .busy(busy), .tmout(tmout)
  );

  task automatic checkOutput(input string name, input int actual, input int required);
    nchecks++;
    if (actual != required) begin
      nfails++;
      $display("[TB] FAIL %s: got %0d, wanted %0d at %0t", name, actual, required, $time);
    end
  endtask

  // who: 0 power-up, 1 A, 2 B; op 7 means no driver activity expected.
  function automatic exp_t mkexp(input int who, input int op, input int arg, input int tmo);
    exp_t e;
    e.who = who;
    e.op  = (op <= 4) ? op : 7;
    e.arg = arg;
    e.tmo = tmo;
    return e;
  endfunction

  // Driver model: initlcd clears the sticky flags; the matching flag rises after a random delay,
  // with occasional unrelated flags that the sequencer must ignore.
  int dly = 0;
  bit pend = 1'b0;
  always @(posedge lcdclk or negedge lcdrstn) begin
    if (!lcdrstn) begin
      doneflags = 5'b00000;
      pend = 1'b0;
    end else begin
      #1;
      if (initlcd) begin
        doneflags = 5'b00000;
        pend = 1'b1;
        dly = $urandom_range(0, 6);
      end else if (pend && !stall && ops != 5'b00000) begin
        if (dly == 0) begin
          doneflags = doneflags | ops;
          pend = 1'b0;
        end else begin : spurious
          int b;
          b = $urandom_range(0, 4);
          dly--;
          if ($urandom_range(0, 5) == 0 && !ops[b]) doneflags[b] = 1'b1;
        end
      end
    end
  end

  int         curop = 7;
  int         ninit = 0;
  int         who;
  logic [7:0] curarg = 8'h00;
  bit         opseen = 1'b0, prevop = 1'b0, prevack = 1'b0, prevready = 1'b0;
  exp_t       e;

  always @(negedge lcdclk) begin
    if (!lcdrstn) begin
      curop = 7; ninit = 0; opseen = 0; prevop = 0; prevack = 0; prevready = 0;
    end else begin
      checkOutput("exclusive", int'($countones(ops) <= 1 && !(initlcd && ops != 5'b00000)), 1);
      checkOutput("ack_both", int'(acka && ackb), 0);
      checkOutput("ack_width", int'((acka || ackb) && prevack), 0);
      if (initlcd) ninit++;
      if (ops != 5'b00000) begin
        if (!opseen) begin
          opseen = 1; curop = $clog2(ops); curarg = lcddatin;
        end else begin
          checkOutput("op_hold", $clog2(ops), curop);
          checkOutput("datin_hold", int'(lcddatin), int'(curarg));
        end
      end
      if (prevop && ops == 5'b00000)
        checkOutput("drop_ack", int'(acka || ackb || (ready && !prevready)), 1);
      if (acka || ackb || (ready && !prevready)) begin
        who = acka ? 1 : (ackb ? 2 : 0);
        if (expq.size() == 0) begin
          nchecks++;
          nfails++;
          $display("[TB] FAIL unexpected: completion for owner %0d, wanted none at %0t", who, $time);
        end else begin
          e = expq.pop_front();
          checkOutput("owner", who, e.who);
          checkOutput("op", curop, e.op);
          if (e.op != 7) checkOutput("arg", int'(curarg), e.arg);
          checkOutput("ninit", ninit, (e.op == 7) ? 0 : 1);
          checkOutput("tmout", int'(tmout), e.tmo);
          checkOutput("busy", int'(busy), 1);
        end
        curop = 7; ninit = 0; opseen = 0;
      end
      prevop = (ops != 5'b00000);
      prevack = acka || ackb;
      prevready = ready;
    end
  end

  task automatic waitReady();
    for (int i = 0; i < 100 && !ready; i++) begin
      @(posedge lcdclk);
      #1;
    end
    checkOutput("ready_up", int'(ready), 1);
  endtask

  // Raise the requested ports together and queue completions in round-robin order.
  task automatic applyStimulus(input bit doa, input bit dob, input logic [2:0] oa,
                               input logic [2:0] ob, input logic [7:0] aa, input logic [7:0] ab);
    if (doa) begin opa = oa; arga = aa; reqa = 1'b1; end
    if (dob) begin opb = ob; argb = ab; reqb = 1'b1; end
    if (doa && dob) begin
      if (lastbm) begin
        expq.push_back(mkexp(1, int'(oa), int'(aa), 0));
        expq.push_back(mkexp(2, int'(ob), int'(ab), 0));
        lastbm = 1'b1;
      end else begin
        expq.push_back(mkexp(2, int'(ob), int'(ab), 0));
        expq.push_back(mkexp(1, int'(oa), int'(aa), 0));
        lastbm = 1'b0;
      end
    end else if (doa) begin
      expq.push_back(mkexp(1, int'(oa), int'(aa), 0));
      lastbm = 1'b0;
    end else if (dob) begin
      expq.push_back(mkexp(2, int'(ob), int'(ab), 0));
      lastbm = 1'b1;
    end
    for (int i = 0; i < 400 && (reqa || reqb); i++) begin
      @(posedge lcdclk);
      #1;
      if (acka) reqa = 1'b0;
      if (ackb) reqb = 1'b0;
    end
    checkOutput("req_served", int'(reqa || reqb), 0);
    reqa = 1'b0;
    reqb = 1'b0;
  endtask

  initial begin
    int mode;
    int n;
    #12;
    checkOutput("rst_outs", int'({acka, ackb, initlcd, ops, ready, busy, tmout}), 0);
    checkOutput("rst_datin", int'(lcddatin), 0);
    @(negedge lcdclk);
    expq.push_back(mkexp(0, 0, 0, 0));
    lcdrstn = 1'b1;
    waitReady();

    applyStimulus(1'b1, 1'b0, 3'd2, 3'd0, 8'h41, 8'h00);
    repeat (4) applyStimulus(1'b1, 1'b1, 3'($urandom_range(0, 4)), 3'($urandom_range(0, 4)),
                             8'($urandom), 8'($urandom));
    applyStimulus(1'b0, 1'b1, 3'd0, 3'd6, 8'h00, 8'($urandom));
    for (int r = 0; r < 40; r++) begin
      mode = $urandom_range(1, 3);
      applyStimulus(mode[0], mode[1], 3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)),
                    8'($urandom), 8'($urandom));
    end

`ifdef LCDSEQ_TIMEOUT_EN
    stall = 1'b1;
    opa = 3'd1;
    arga = 8'h5a;
    reqa = 1'b1;
    expq.push_back(mkexp(1, 1, 'h5a, 1));
    lastbm = 1'b0;
    for (int i = 0; i < 50 && !clearlcd; i++) begin
      @(posedge lcdclk);
      #1;
    end
    n = 0;
    for (int i = 0; i < 100 && !acka; i++) begin
      @(posedge lcdclk);
      #1;
      n++;
    end
    checkOutput("tmo_latency", n, TMO + 1);
    reqa = 1'b0;
    stall = 1'b0;
`endif

    stall = 1'b1;
    opb = 3'd3;
    argb = 8'h85;
    reqb = 1'b1;
    for (int i = 0; i < 50 && !addrlcd; i++) begin
      @(posedge lcdclk);
      #1;
    end
    checkOutput("rw_addr", int'(addrlcd), 1);
    checkOutput("rw_datin", int'(lcddatin), 'h85);
    repeat (3) @(posedge lcdclk);
    #3 lcdrstn = 1'b0;
    #1;
    checkOutput("rw_outs", int'({acka, ackb, initlcd, ops, ready, busy, tmout}), 0);
    checkOutput("rw_datin0", int'(lcddatin), 0);
    reqb = 1'b0;
    stall = 1'b0;
    lastbm = 1'b0;
    repeat (2) @(negedge lcdclk);
    expq.push_back(mkexp(0, 0, 0, 0));
    lcdrstn = 1'b1;
    waitReady();

    applyStimulus(1'b1, 1'b1, 3'd2, 3'd3, 8'h30, 8'h8f);
    repeat (3) @(posedge lcdclk);
    checkOutput("queue_empty", expq.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", nchecks, nfails);
    $finish;
  end

endmodule

// File: doc/lcdseq_arb.md
# lcdseq_arb

Command sequencer and two-port arbiter for the serial LCD driver. Two requesters (e.g. keyboard echo, status line) submit single LCD commands (reset, clear, data, address, erase) over a req/ack handshake. The block grants them round-robin and drives the driver's init/strobe/done protocol one command at a time. After reset it autonomously issues an LCD reset command before accepting requests.

## Interface
- TMOUT, default 4096: WAIT-state cycle limit (used only with LCDSEQ_TIMEOUT_EN).
- lcdclk  in  1  system clock; all state on rising edge.
- lcdrstn  in  1  reset, asynchronous, active-low.
- reqa / reqb  in  1  requester A/B command request, level, held until ack.
- opa / opb  in  3  opcode: 0 reset, 1 clear, 2 data, 3 addr, 4 erase, 5-7 illegal.
- arga / argb  in  8  operand: character (data), row/col (addr: bit7 row, [3:0] col), '0'/'1'/'2' (erase).
- acka / ackb  out  1  one-cycle completion pulse to requester A/B.
- initlcd  out  1  driver init strobe.
- resetlcd, clearlcd, datalcd, addrlcd, eraselcd  out  1  driver op lines, at most one high.
- lcddatin  out  8  driver operand.
- lcdreset, lcdclear, lcddata, lcdaddr, lcderase  in  1  driver done flags, sticky until next initlcd.
- ready  out  1  power-up LCD reset complete.
- busy  out  1  command in progress (state not IDLE).
- tmout  out  1  one-cycle timeout pulse (0 without macro).

## Operation
- States: PWRUP, INIT, ISSUE, WAIT, RELEASE, IDLE.
- On reset: all outputs 0, lcddatin=0, state PWRUP, rr pointer = A, ready=0.
- PWRUP: latch op=0 (reset), owner=none; go INIT.
- IDLE: if only one req high, grant it; if both, grant the one not granted last; latch op/arg/owner, update rr pointer; go INIT. No req: stay.
- Illegal opcode at grant: no driver activity; go directly to RELEASE (ack pulse only).
- INIT: initlcd=1 for exactly one cycle, no op line high; go ISSUE.
- ISSUE: assert op line decoded from latched op; lcddatin=latched arg; go WAIT.
- WAIT: hold op line and lcddatin; when the done flag matching op is 1, go RELEASE. Other done flags ignored.
- RELEASE: op line=0; ack of owner=1 for one cycle (none for power-up; ready set instead); go IDLE.
- lcddatin holds latched arg from ISSUE until next grant.
- Requester rule: keep req/op/arg stable until ack; drop req on the edge ack is seen. Req still high in IDLE = new request.
- Asynchronous reset mid-command: outputs 0 immediately; power-up sequence reruns. initlcd restarts the driver, which returns ss high.

## Timing
- Grant edge (IDLE->INIT) to initlcd high: 1 cycle. initlcd high to op line high: 1 cycle.
- Done flag sampled high at edge N: op line low and ack high in cycle N+1; IDLE at N+2.
- Minimum req-to-ack overhead excluding driver time: 4 cycles. Illegal op: ack 1 cycle after grant.
- Back-to-back: next grant earliest 1 cycle after ack; no initlcd/op-line overlap ever.
- Never two op lines high simultaneously; initlcd never high with an op line.

## Configuration
- LCDSEQ_TIMEOUT_EN defined: counter clears on ISSUE, increments in WAIT. On reaching TMOUT without done: go RELEASE, op line dropped, owner acked, tmout=1 same cycle. Power-up timeout still sets ready.
- Not defined: WAIT unbounded; no counter; tmout tied 0.

## Test plan
- Power-up: release lcdrstn -> initlcd one pulse, resetlcd high until model raises lcdreset, then ready=1, no acka/ackb.
- Single data: reqa, opa=2, arga=8'h41 -> initlcd, datalcd high with lcddatin=8'h41 until lcddata, then acka single pulse; ackb stays 0.
- Contention: reqa and reqb together, A granted last -> B served first (ackb), then A (acka); order alternates over 4 repeated pairs.
- Illegal op: reqb, opb=6 -> ackb 1 cycle after grant, initlcd and all op lines stay 0.
- Reset mid-WAIT of addr op (argb=8'h85) -> all outputs 0 asynchronously; on release the power-up reset reruns, no ackb.
- With LCDSEQ_TIMEOUT_EN, TMOUT=16, model never sets lcdclear -> clearlcd drops and acka+tmout pulse 17 cycles after ISSUE.
